// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch/decode decoupling queue.
package inst_queue_pkg;

  localparam int REG_BUS_W    = 32;
  localparam int INST_ADDR_W  = 32;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [REG_BUS_W-1:0]   inst;
    logic [REG_BUS_W-1:0]   except_type;
  } fetch_entry_t;

endpackage

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction FIFO. Entries are {pc, inst, except_type};
// a flush discards everything queued. Head is a combinational read.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [INST_ADDR_W-1:0] in_pc,
  input  logic [REG_BUS_W-1:0]   in_inst,
  input  logic [REG_BUS_W-1:0]   in_except_type,
  output logic                   in_ready,
  output logic                   out_valid,
  output logic [INST_ADDR_W-1:0] out_pc,
  output logic [REG_BUS_W-1:0]   out_inst,
  output logic [REG_BUS_W-1:0]   out_except_type,
  input  logic                   out_ready,
  output logic [PTR_W:0]         count
);

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  fetch_entry_t     head;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push;
  logic             pop;

  // Handshake qualification; a flush suppresses both sides of the cycle.
  always_comb begin
    in_ready  = (count != CNT_FULL);
    out_valid = (count != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Head entry is read straight out of storage; stale when empty.
  always_comb begin
    head            = mem[rd_ptr];
    out_pc          = head.pc;
    out_inst        = head.inst;
    out_except_type = head.except_type;
  end

  // Write pointer advances on each accepted push, wrapping at PTR_W bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       wr_ptr <= '0;
    else if (flush) wr_ptr <= '0;
    else if (push)  wr_ptr <= wr_ptr + PTR_ONE;
  end

  // Read pointer advances on each pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       rd_ptr <= '0;
    else if (flush) rd_ptr <= '0;
    else if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
  end

  // Occupancy: simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               count <= '0;
    else if (flush)         count <= '0;
    else if (push && !pop)  count <= count + CNT_ONE;
    else if (pop && !push)  count <= count - CNT_ONE;
  end

  // Storage write; contents survive a flush, only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= '{pc: in_pc, inst: in_inst, except_type: in_except_type};
    end
  end

endmodule
